stream_loopback_tester: RTL and testbench

//  Self-checking traffic source/sink for 128-bit valid/rdy streams. It drives the input

---
 rtl/stream_loopback_tester.sv | 185 ++++++++++++++++++
 tb/tb_stream_loopback_tester.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_loopback_tester.sv
// Traffic source/sink for a 128-bit valid/rdy loopback checksum block.
// Sends {~lo,~lo,~lo,lo} words with lo = seed + tx_idx and checks each
// response as {.., running sum of lo, lo}, counting mismatches per run.
module stream_loopback_tester #(
  parameter int unsigned TIMEOUT   = 1024,
  parameter bit          STALL_EN  = 1'b0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [31:0]  num_words_i,
  input  logic [31:0]  seed_i,
  output logic         tx_valid_o,
  input  logic         tx_rdy_i,
  output logic [127:0] tx_data_o,
  input  logic         rx_valid_i,
  output logic         rx_rdy_o,
  input  logic [127:0] rx_data_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         pass_o,
  output logic         timeout_o,
  output logic [15:0]  err_count_o,
  output logic [31:0]  first_err_idx_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [31:0]   nw_q, nw_d, seed_q, seed_d;
  logic [31:0]   tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic [31:0]   sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tx_valid_q, tx_valid_d;
  logic          busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
  logic [15:0]   err_q, err_d;
  logic [31:0]   ferr_q, ferr_d;
  logic [15:0]   lfsr_q;

  logic        tx_gate, tx_hs, rx_rdy, rx_hs, mism, finish;
  logic [31:0] tx_lo, tx_next, exp_lo, exp_sum;
  logic        unused_rx_hi;

  // Upper response half is not part of the check.
  assign unused_rx_hi = ^rx_data_i[127:64];

  // A new tx word may only be raised when the stall LFSR allows it.
  assign tx_gate = ~STALL_EN | lfsr_q[0];
  assign tx_hs   = tx_valid_q & tx_rdy_i;
  assign rx_rdy  = (state_q == RUN) & (rx_idx_q < nw_q) & (~STALL_EN | lfsr_q[1]);
  assign rx_hs   = rx_valid_i & rx_rdy;

  // tx_data is a pure function of held registers, so it is stable while stalled.
  assign tx_lo   = seed_q + tx_idx_q;
  assign exp_lo  = seed_q + rx_idx_q;
  assign exp_sum = sum_q + exp_lo;
  assign mism    = (rx_data_i[31:0] != exp_lo) | (rx_data_i[63:32] != exp_sum);

  assign tx_valid_o      = tx_valid_q;
  assign tx_data_o       = {~tx_lo, ~tx_lo, ~tx_lo, tx_lo};
  assign rx_rdy_o        = rx_rdy;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign timeout_o       = timeout_q;
  assign err_count_o     = err_q;
  assign first_err_idx_o = ferr_q;
  assign pass_o          = done_q & (err_q == 16'd0) & ~timeout_q;

  // Run control: start/latch, tx word sequencing, response checking, timeout.
  always_comb begin
    state_d    = state_q;
    nw_d       = nw_q;
    seed_d     = seed_q;
    tx_idx_d   = tx_idx_q;
    rx_idx_d   = rx_idx_q;
    sum_d      = sum_q;
    tmo_d      = tmo_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    ferr_d     = ferr_q;
    finish     = 1'b0;
    tx_next    = tx_idx_q + {31'd0, tx_hs};
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          nw_d      = num_words_i;
          seed_d    = seed_i;
          tx_idx_d  = '0;
          rx_idx_d  = '0;
          sum_d     = '0;
          tmo_d     = '0;
          err_d     = '0;
          ferr_d    = '0;
          timeout_d = 1'b0;
          if (num_words_i == 32'd0) begin
            state_d    = DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            tx_valid_d = 1'b0;
          end else begin
            state_d    = RUN;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            tx_valid_d = tx_gate;
          end
        end
      end
      RUN: begin
        tx_idx_d = tx_next;
        // A raised word is held until accepted; otherwise offer the next one.
        if (!(tx_valid_q && !tx_rdy_i))
          tx_valid_d = (tx_next < nw_q) & tx_gate;
        if (rx_hs) begin
          sum_d    = exp_sum;
          rx_idx_d = rx_idx_q + 32'd1;
          tmo_d    = '0;
          if (mism) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0)    ferr_d = rx_idx_q;
          end
          if (rx_idx_q + 32'd1 == nw_q) finish = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TW'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            finish    = 1'b1;
          end
        end
        if (finish) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          tx_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      nw_q       <= '0;
      seed_q     <= '0;
      tx_idx_q   <= '0;
      rx_idx_q   <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
      ferr_q     <= '0;
    end else begin
      state_q    <= state_d;
      nw_q       <= nw_d;
      seed_q     <= seed_d;
      tx_idx_q   <= tx_idx_d;
      rx_idx_q   <= rx_idx_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      ferr_q     <= ferr_d;
    end
  end

  // Stall LFSR, x^16+x^14+x^13+x^11+1, free-running outside reset.
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

endmodule

// File: tb/tb_stream_loopback_tester.sv
// Bench for stream_loopback_tester: two instances (no-stall with short timeout,
// stalling with default timeout), each wired to a behavioural loopback block.
module tb_stream_loopback_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst[2], start[2], tx_valid[2], tx_rdy[2], rx_valid[2], rx_rdy[2];
  logic [31:0]  num_words[2], seed[2], first_err_idx[2];
  logic [127:0] tx_data[2], rx_data[2];
  logic         busy[2], done[2], pass[2], timeout[2];
  logic [15:0]  err_count[2];

  int checks = 0;
  int errors = 0;

  // Loopback model state and per-run controls.
  int unsigned  rdy_pct[2];
  bit           mute[2];
  int           inj_idx[2];
  logic [31:0]  seed_r[2];
  int           txcnt[2], rxcnt[2];
  logic [31:0]  lbsum[2];
  logic         prev_stall[2];
  logic [127:0] prev_data[2];
  logic [127:0] resp[2][1024];
  logic [31:0]  sumlog[2][8];

  stream_loopback_tester #(.TIMEOUT(16), .STALL_EN(1'b0), .LFSR_SEED(16'hACE1)) dut0 (
    .clk(clk), .rst(rst[0]), .start_i(start[0]), .num_words_i(num_words[0]), .seed_i(seed[0]),
    .tx_valid_o(tx_valid[0]), .tx_rdy_i(tx_rdy[0]), .tx_data_o(tx_data[0]),
    .rx_valid_i(rx_valid[0]), .rx_rdy_o(rx_rdy[0]), .rx_data_i(rx_data[0]),
    .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .timeout_o(timeout[0]),
    .err_count_o(err_count[0]), .first_err_idx_o(first_err_idx[0]));

  stream_loopback_tester #(.TIMEOUT(1024), .STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) dut1 (
    .clk(clk), .rst(rst[1]), .start_i(start[1]), .num_words_i(num_words[1]), .seed_i(seed[1]),
    .tx_valid_o(tx_valid[1]), .tx_rdy_i(tx_rdy[1]), .tx_data_o(tx_data[1]),
    .rx_valid_i(rx_valid[1]), .rx_rdy_o(rx_rdy[1]), .rx_data_i(rx_data[1]),
    .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .timeout_o(timeout[1]),
    .err_count_o(err_count[1]), .first_err_idx_o(first_err_idx[1]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Loopback checksum block: echoes each tx low word with the running sum.
  // Inputs change on the falling edge; handshakes complete on the next rising edge.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst[u] || (start[u] && !busy[u])) begin
        txcnt[u] = 0; rxcnt[u] = 0; lbsum[u] = '0; prev_stall[u] = 1'b0;
        tx_rdy[u] = 1'b0; rx_valid[u] = 1'b0; rx_data[u] = '0;
      end else begin
        if (prev_stall[u] && !done[u]) begin
          chk("tx_hold_valid", tx_valid[u], 1'b1);
          chk("tx_hold_data", tx_data[u], prev_data[u]);
        end
        tx_rdy[u]   = ($urandom_range(0, 99) < rdy_pct[u]);
        rx_valid[u] = !mute[u] && (rxcnt[u] < txcnt[u]) && ($urandom_range(0, 99) < rdy_pct[u]);
        if (rx_valid[u]) begin
          rx_data[u] = resp[u][rxcnt[u][9:0]];
          if (rxcnt[u] == inj_idx[u]) rx_data[u][40] = ~rx_data[u][40];
        end else begin
          rx_data[u] = {$urandom, $urandom, $urandom, $urandom};
        end
        if (tx_valid[u] && tx_rdy[u]) begin
          logic [31:0] e;
          e = seed_r[u] + 32'(txcnt[u]);
          chk("tx_data", tx_data[u], {~e, ~e, ~e, e});
          lbsum[u] = lbsum[u] + tx_data[u][31:0];
          resp[u][txcnt[u][9:0]] = {$urandom, $urandom, lbsum[u], tx_data[u][31:0]};
          txcnt[u]++;
        end
        if (rx_valid[u] && rx_rdy[u]) begin
          if (rxcnt[u] < 8) sumlog[u][rxcnt[u][2:0]] = rx_data[u][63:32];
          rxcnt[u]++;
        end
        if (!busy[u]) chk("rx_rdy_idle", rx_rdy[u], 1'b0);
        prev_stall[u] = tx_valid[u] && !tx_rdy[u];
        prev_data[u]  = tx_data[u];
      end
    end
  end

  task automatic pulse_start(input int u, input int n, input logic [31:0] sd);
    seed_r[u] = sd;
    @(posedge clk); #1;
    num_words[u] = 32'(n); seed[u] = sd; start[u] = 1'b1;
    @(posedge clk); #1;
    start[u] = 1'b0;
  endtask

  // Full run; expected status follows from the injected fault (if any).
  task automatic do_run(input int u, input int n, input logic [31:0] sd, input int inj,
                        input int poke, input string tag);
    int cyc;
    int exp_err;
    inj_idx[u] = inj;
    pulse_start(u, n, sd);
    cyc = 0;
    while (!done[u] && cyc < 20000) begin
      if (cyc == poke) begin
        start[u] = 1'b1; num_words[u] = 32'd3; seed[u] = 32'hDEAD0000;
      end else begin
        start[u] = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start[u] = 1'b0;
    exp_err = (inj >= 0 && inj < n) ? 1 : 0;
    chk({tag, " done"}, done[u], 1'b1);
    chk({tag, " busy"}, busy[u], 1'b0);
    chk({tag, " timeout"}, timeout[u], 1'b0);
    chk({tag, " err_count"}, err_count[u], 16'(exp_err));
    chk({tag, " pass"}, pass[u], (exp_err == 0));
    if (exp_err != 0) chk({tag, " first_err_idx"}, first_err_idx[u], 32'(inj));
    chk({tag, " rx_words"}, rxcnt[u], n);
    chk({tag, " tx_words"}, txcnt[u], n);
    chk({tag, " tx_valid_idle"}, tx_valid[u], 1'b0);
  endtask

  task automatic chk_clear(input int u, input string tag);
    chk({tag, " busy"}, busy[u], 1'b0);
    chk({tag, " done"}, done[u], 1'b0);
    chk({tag, " pass"}, pass[u], 1'b0);
    chk({tag, " timeout"}, timeout[u], 1'b0);
    chk({tag, " err_count"}, err_count[u], 16'd0);
    chk({tag, " first_err_idx"}, first_err_idx[u], 32'd0);
    chk({tag, " tx_valid"}, tx_valid[u], 1'b0);
    chk({tag, " rx_rdy"}, rx_rdy[u], 1'b0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; start[u] = 1'b0; num_words[u] = '0; seed[u] = '0;
      rdy_pct[u] = 100; mute[u] = 1'b0; inj_idx[u] = -1; seed_r[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk_clear(0, "reset0");
    chk_clear(1, "reset1");

    // Directed loopback runs on the non-stalling instance.
    do_run(0, 4, 32'h10, -1, -1, "basic");
    chk("basic sum0", sumlog[0][0], 32'h10);
    chk("basic sum1", sumlog[0][1], 32'h21);
    chk("basic sum2", sumlog[0][2], 32'h33);
    chk("basic sum3", sumlog[0][3], 32'h46);
    do_run(0, 3, 32'hFFFFFFFE, -1, -1, "wrap");
    chk("wrap sum0", sumlog[0][0], 32'hFFFFFFFE);
    chk("wrap sum1", sumlog[0][1], 32'hFFFFFFFD);
    chk("wrap sum2", sumlog[0][2], 32'hFFFFFFFD);
    do_run(0, 8, 32'h1234, 2, -1, "errinj");

    // Responses withheld: abort after exactly 16 RUN cycles.
    mute[0] = 1'b1; inj_idx[0] = -1;
    pulse_start(0, 8, 32'h100);
    repeat (15) @(posedge clk);
    #1;
    chk("tmo early timeout", timeout[0], 1'b0);
    chk("tmo early done", done[0], 1'b0);
    @(posedge clk); #1;
    chk("tmo timeout", timeout[0], 1'b1);
    chk("tmo done", done[0], 1'b1);
    chk("tmo pass", pass[0], 1'b0);
    chk("tmo busy", busy[0], 1'b0);
    chk("tmo tx_valid", tx_valid[0], 1'b0);
    mute[0] = 1'b0;

    // Empty run finishes the cycle after start and clears the earlier timeout.
    pulse_start(0, 0, 32'h5);
    chk("n0 done", done[0], 1'b1);
    chk("n0 pass", pass[0], 1'b1);
    chk("n0 timeout", timeout[0], 1'b0);
    chk("n0 busy", busy[0], 1'b0);

    // Start during RUN must not disturb the run in progress.
    do_run(0, 20, 32'hCAFE0000, -1, 3, "poke");

    // Random runs on both instances.
    rdy_pct[0] = 80; rdy_pct[1] = 50;
    for (int k = 0; k < 8; k++) begin
      int n;
      int inj;
      n   = int'($urandom_range(1, 40));
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
      do_run(k % 2, n, $urandom, inj, -1, "rand");
    end

    // Long stalled run with random tx_rdy.
    do_run(1, 1000, $urandom, -1, -1, "stall1000");

    // Reset mid-run, then a clean run.
    pulse_start(1, 50, 32'h77);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst busy", busy[1], 1'b1);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk_clear(1, "midrst");
    do_run(1, 4, 32'h10, -1, -1, "after_rst");
    chk("after_rst sum3", sumlog[1][3], 32'h46);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: time %0t reached, limit 900000", $time);
    $fatal(1, "bench did not complete");
  end

endmodule
